// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle datapath (master)
// and its control unit (slave).
interface multicycle_control_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_write;
  logic               reg_dst;
  logic               alu_src_a;
  logic [1:0]         pc_source;
  logic [1:0]         alu_op;
  logic [1:0]         alu_src_b;
  logic [3:0]         state;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
           alu_src_b, state, halted, instr_count
  );

  modport slave (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
           alu_src_b, state, halted, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM with registered datapath
// controls and a wrapping counter of completed instruction fetches.
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11,
    HALT    = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       halted;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e             state_q, state_d;
  ctrl_t              ctrl_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               fetchStrobe;

  // Moore decode of one state; registered so outputs switch with the state.
  function automatic ctrl_t decodeCtrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDI_WB: c.reg_write = 1'b1;
      HALT:    c.halted    = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready) begin
          state_d = DECODE;
          count_d = count_q + COUNT_W'(1);
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default:      state_d = HALT;
        endcase
      end
      MEMADR:  state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (bus.mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (bus.mem_ready) state_d = FETCH;
      EXEC:    state_d = RWB;
      RWB:     state_d = FETCH;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      ADDI_EX: state_d = ADDI_WB;
      ADDI_WB: state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Reset loads the FETCH decode directly, so an aborted memory or register
  // strobe drops the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      ctrl_q  <= decodeCtrl(FETCH);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decodeCtrl(state_d);
      count_q <= count_d;
    end
  end

  // Instruction-register load and PC increment complete with the memory read.
  assign fetchStrobe = (state_q == FETCH) && bus.mem_ready && rst;

  assign bus.pc_write      = ctrl_q.pc_write | fetchStrobe;
  assign bus.ir_write      = fetchStrobe;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.iord          = ctrl_q.iord;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.halted        = ctrl_q.halted;
  assign bus.state         = state_q;
  assign bus.instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-state control vectors,
// memory waits, async reset abort, HALT behaviour and counter wrap.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_control_if #(.COUNT_W(4)) bus ();

  multicycle_control #(.COUNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_write, reg_dst, alu_src_a, pc_source, alu_op, alu_src_b, halted}
  logic [16:0] ctrlVec;
  assign ctrlVec = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                    bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_write,
                    bus.reg_dst, bus.alu_src_a, bus.pc_source, bus.alu_op,
                    bus.alu_src_b, bus.halted};

  localparam logic [16:0] C_FETCH_GO   = 17'b1_0_0_1_0_1_0_0_0_0_00_00_01_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_00_00_01_0;
  localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_00_00_11_0;
  localparam logic [16:0] C_MEMADR     = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [16:0] C_MEMRD      = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB      = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR      = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC       = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_RWB        = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BRANCH     = 17'b0_1_0_0_0_0_0_0_0_1_01_01_00_0;
  localparam logic [16:0] C_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_0;
  localparam logic [16:0] C_ADDI_WB    = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;
  localparam logic [16:0] C_HALT       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ILL   = 6'b111111;

  // Drive inputs early in the cycle and let combinational gating settle.
  task automatic applyStimulus(input logic [5:0] op, input logic ready);
    bus.opcode    = op;
    bus.mem_ready = ready;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: check current state and controls, then clock.
  task automatic step(input string tag, input logic [5:0] op, input logic ready,
                      input logic [3:0] expState, input logic [16:0] expCtrl);
    applyStimulus(op, ready);
    checkOutput({tag, "_state"}, 32'(bus.state), 32'(expState));
    checkOutput({tag, "_ctrl"}, 32'(ctrlVec), 32'(expCtrl));
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.opcode    = OP_RTYPE;
    bus.mem_ready = 1'b1;

    // Reset holds FETCH decode with strobes suppressed even though mem_ready=1.
    tick();
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_count", 32'(bus.instr_count), 32'd0);
    checkOutput("rst_ctrl", 32'(ctrlVec), 32'(C_FETCH_WAIT));
    rst = 1'b1;
    #1;

    // R-type: 0,1,6,7,0
    step("rt_f", OP_RTYPE, 1'b1, 4'd0, C_FETCH_GO);
    step("rt_d", OP_RTYPE, 1'b1, 4'd1, C_DECODE);
    step("rt_ex", OP_RTYPE, 1'b1, 4'd6, C_EXEC);
    step("rt_wb", OP_RTYPE, 1'b1, 4'd7, C_RWB);
    applyStimulus(OP_LW, 1'b0);
    checkOutput("rt_end_state", 32'(bus.state), 32'd0);
    checkOutput("rt_count", 32'(bus.instr_count), 32'd1);

    // lw with 2 fetch waits and 3 read waits: 10 cycles
    step("lw_fw0", OP_LW, 1'b0, 4'd0, C_FETCH_WAIT);
    step("lw_fw1", OP_LW, 1'b0, 4'd0, C_FETCH_WAIT);
    step("lw_f", OP_LW, 1'b1, 4'd0, C_FETCH_GO);
    step("lw_d", OP_LW, 1'b1, 4'd1, C_DECODE);
    step("lw_ma", OP_LW, 1'b1, 4'd2, C_MEMADR);
    step("lw_rw0", OP_LW, 1'b0, 4'd3, C_MEMRD);
    step("lw_rw1", OP_LW, 1'b0, 4'd3, C_MEMRD);
    step("lw_rw2", OP_LW, 1'b0, 4'd3, C_MEMRD);
    step("lw_rd", OP_LW, 1'b1, 4'd3, C_MEMRD);
    step("lw_wb", OP_LW, 1'b1, 4'd4, C_MEMWB);
    applyStimulus(OP_SW, 1'b1);
    checkOutput("lw_end_state", 32'(bus.state), 32'd0);
    checkOutput("lw_count", 32'(bus.instr_count), 32'd2);

    // sw with no waits: 4 cycles
    step("sw_f", OP_SW, 1'b1, 4'd0, C_FETCH_GO);
    step("sw_d", OP_SW, 1'b1, 4'd1, C_DECODE);
    step("sw_ma", OP_SW, 1'b1, 4'd2, C_MEMADR);
    step("sw_wr", OP_SW, 1'b1, 4'd5, C_MEMWR);

    // beq then j
    step("beq_f", OP_BEQ, 1'b1, 4'd0, C_FETCH_GO);
    step("beq_d", OP_BEQ, 1'b1, 4'd1, C_DECODE);
    step("beq_br", OP_BEQ, 1'b1, 4'd8, C_BRANCH);
    step("j_f", OP_J, 1'b1, 4'd0, C_FETCH_GO);
    step("j_d", OP_J, 1'b1, 4'd1, C_DECODE);
    step("j_jp", OP_J, 1'b1, 4'd9, C_JUMP);
    applyStimulus(OP_SW, 1'b1);
    checkOutput("cf_end_state", 32'(bus.state), 32'd0);
    checkOutput("cf_count", 32'(bus.instr_count), 32'd5);

    // sw stalled in MEMWR, then reset between edges aborts the write
    step("swa_f", OP_SW, 1'b1, 4'd0, C_FETCH_GO);
    step("swa_d", OP_SW, 1'b1, 4'd1, C_DECODE);
    step("swa_ma", OP_SW, 1'b1, 4'd2, C_MEMADR);
    step("swa_w0", OP_SW, 1'b0, 4'd5, C_MEMWR);
    applyStimulus(OP_SW, 1'b0);
    checkOutput("swa_w1_state", 32'(bus.state), 32'd5);
    checkOutput("swa_w1_memwr", 32'(bus.mem_write), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("arst_state", 32'(bus.state), 32'd0);
    checkOutput("arst_memwr", 32'(bus.mem_write), 32'd0);
    checkOutput("arst_count", 32'(bus.instr_count), 32'd0);
    checkOutput("arst_ctrl", 32'(ctrlVec), 32'(C_FETCH_WAIT));
    tick();
    rst = 1'b1;
    #1;

    // 17 addi instructions wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      step("addi_f", OP_ADDI, 1'b1, 4'd0, C_FETCH_GO);
      step("addi_d", OP_ADDI, 1'b1, 4'd1, C_DECODE);
      step("addi_ex", OP_ADDI, 1'b1, 4'd10, C_MEMADR);
      step("addi_wb", OP_ADDI, 1'b1, 4'd11, C_ADDI_WB);
    end
    applyStimulus(OP_ADDI, 1'b0);
    checkOutput("wrap_count", 32'(bus.instr_count), 32'd1);

    // Illegal opcode after a fresh reset: DECODE then HALT
    rst = 1'b0;
    #1;
    checkOutput("ill_rst_count", 32'(bus.instr_count), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    step("ill_f", OP_ILL, 1'b1, 4'd0, C_FETCH_GO);
    step("ill_d", OP_ILL, 1'b1, 4'd1, C_DECODE);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(OP_ILL, 1'($urandom_range(0, 1)));
      checkOutput("halt_state", 32'(bus.state), 32'd15);
      checkOutput("halt_ctrl", 32'(ctrlVec), 32'(C_HALT));
      checkOutput("halt_count", 32'(bus.instr_count), 32'd1);
      tick();
    end
    rst = 1'b0;
    #1;
    checkOutput("unhalt_state", 32'(bus.state), 32'd0);
    checkOutput("unhalt_count", 32'(bus.instr_count), 32'd0);
    checkOutput("unhalt_halted", 32'(bus.halted), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    step("post_f", OP_RTYPE, 1'b1, 4'd0, C_FETCH_GO);
    applyStimulus(OP_RTYPE, 1'b1);
    checkOutput("post_state", 32'(bus.state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 32, width of the retired-fetch counter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 opcode  input  6  instr[31:26] from the instruction register; sampled in DECODE and MEMADR only.
REQ-005 mem_ready  input  1  memory handshake; 1 = the access presented this cycle completes this cycle.
REQ-006 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  output  1 each  datapath controls.
REQ-007 pc_source  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
REQ-008 alu_op  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-009 alu_src_b  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 state  output  4  current state encoding.
REQ-011 halted  output  1  1 while in HALT.
REQ-012 instr_count  output  COUNT_W  number of completed fetches.

Function
REQ-013 The FSM SHALL be Moore. The only exception is ir_write/pc_write in FETCH, which are additionally gated by mem_ready. Every control not listed for a state SHALL be 0.
REQ-014 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=15. Codes 12-14 SHALL go to HALT on the next edge.
REQ-015 FETCH: mem_read=1, alu_src_b=01. ir_write=1 and pc_write=1 only when mem_ready=1. Go to DECODE when mem_ready=1; otherwise hold FETCH.
REQ-016 DECODE: alu_src_b=11. Next state by opcode:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDI_EX
- any other opcode -> HALT
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10. Go to MEMRD if opcode=100011, else MEMWR.
REQ-018 MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
REQ-019 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
REQ-020 MEMWR: mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH. mem_write SHALL stay asserted for every wait cycle.
REQ-021 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
REQ-022 RWB: reg_dst=1, reg_write=1. Go to FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
REQ-024 JUMP: pc_write=1, pc_source=10. Go to FETCH.
REQ-025 ADDI_EX: alu_src_a=1, alu_src_b=10. Go to ADDI_WB.
REQ-026 ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
REQ-027 HALT: all controls 0, halted=1. Stay in HALT until reset; mem_ready is ignored.
REQ-028 Latency with mem_ready held at 1 (cycles, FETCH through the return to FETCH exclusive):
- lw = 5
- sw = 4
- R-type = 4
- addi = 4
- beq = 3
- j = 3
Each memory wait cycle SHALL add exactly 1.
REQ-029 instr_count SHALL increment by 1 on each FETCH->DECODE transition. It SHALL wrap from 2^COUNT_W-1 to 0. It SHALL not change in any other state, including HALT.
REQ-030 At most one of mem_read and mem_write SHALL be 1 in any cycle.
REQ-031 reg_write and pc_write SHALL never be 1 in the same cycle.

Reset
REQ-032 While rst=0, regardless of clk, the block SHALL hold:
- state=FETCH
- instr_count=0
- halted=0
REQ-033 Outputs under reset SHALL follow the FETCH decode: mem_read=1, alu_src_b=01. ir_write and pc_write SHALL be forced to 0 while rst=0.
REQ-034 Reset asserted mid-instruction (any state, including a memory wait) SHALL abort that instruction with no further register or memory write strobe. Deassertion SHALL resume at FETCH on the next rising edge.

Verification
REQ-035 R-type: opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0. reg_dst=reg_write=1 in state 7 only. instr_count 0->1.
REQ-036 lw with waits: opcode=100011, mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD -> sequence 0,0,0,1,2,3,3,3,3,4,0. ir_write high exactly one cycle. Total 10 cycles.
REQ-037 Control-flow pair: beq -> states 0,1,8,0 with pc_write_cond=1 and pc_source=01 in state 8. j -> states 0,1,9,0 with pc_write=1 and pc_source=10 in state 9.
REQ-038 Illegal opcode 111111 -> DECODE then HALT. Then halted=1 and all controls 0 for 20 cycles of random mem_ready. instr_count frozen at 1. rst=0 returns state=0, count=0.
REQ-039 Async reset in MEMWR wait (mem_ready=0): rst falls between edges -> state=0 and mem_write=0 immediately, no clk edge needed.
REQ-040 Wrap: COUNT_W=4, run 17 addi instructions -> instr_count reads 1. Each instruction takes 4 cycles (0,1,10,11).
